id_issue_ctrl: RTL

//  Issue controller for the decode stage. Sits between ID and EX and decides each cycle whether
//  the decoded instruction may issue. It keeps a scoreboard of in-flight load destinations
//  (load-use and WAW interlock) and a busy counter for the multi-cycle HI/LO mult/div unit.
//  It drives the ID/EX handshake: ID holds while id_ready=0, and EX captures when ex_valid=1.

---
 rtl/id_issue_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: load scoreboard interlock, HI/LO mult/div busy
// tracking and the ID/EX valid/ready handshake.
module id_issue_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rreg_a,
  input  logic [4:0]  id_rreg_b,
  input  logic        id_use_a,
  input  logic        id_use_b,
  input  logic [4:0]  id_wreg,
  input  logic        id_wen,
  input  logic        id_is_load,
  input  logic        id_is_muldiv,
  input  logic        id_use_hilo,
  input  logic        ex_ready,
  input  logic        wb_load_valid,
  input  logic [4:0]  wb_load_wreg,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [1:0]  stall_cause,
  output logic [31:0] sb_pending,
  output logic        muldiv_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_LOAD = 2'd1,
    CAUSE_MD   = 2'd2,
    CAUSE_BP   = 2'd3
  } cause_t;

  logic [31:0]      sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      wb_clr_mask;
  logic [31:0]      id_set_mask;
  logic [31:0]      eff;
  logic             haz_load;
  logic             haz_md;
  logic             issue;
  cause_t           cause;

  // A load committing this cycle is bypassed, so its register no longer interlocks.
  always_comb begin
    wb_clr_mask = wb_load_valid ? (32'd1 << wb_load_wreg) : 32'd0;
    id_set_mask = (id_wreg != 5'd0) ? (32'd1 << id_wreg) : 32'd0;
    eff         = sb_q & ~wb_clr_mask;
  end

  always_comb begin
    haz_load = id_valid & ((id_use_a & eff[id_rreg_a]) |
                           (id_use_b & eff[id_rreg_b]) |
                           (id_wen   & eff[id_wreg]));
    haz_md   = id_valid & (id_is_muldiv | id_use_hilo) & muldiv_busy;
    issue    = rst_n & id_valid & ~haz_load & ~haz_md & ex_ready;

    cause = CAUSE_NONE;
    if (rst_n && id_valid && !issue) begin
      if (haz_load)    cause = CAUSE_LOAD;
      else if (haz_md) cause = CAUSE_MD;
      else             cause = CAUSE_BP;
    end
  end

  assign ex_valid    = issue;
  assign id_ready    = ~rst_n | ~id_valid | issue;
  assign stall_cause = cause;
  assign sb_pending  = sb_q;
  assign muldiv_busy = (cnt_q != '0);

  // Clear-then-set ordering makes a same-cycle writeback and re-issue leave the bit set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else if (issue && id_is_load && id_wen) begin
      sb_q <= (sb_q & ~wb_clr_mask) | id_set_mask;
    end else begin
      sb_q <= sb_q & ~wb_clr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (issue && id_is_muldiv) begin
      cnt_q <= CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule
